// File: rtl/mips_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding,
// the data value returned when a bus access times out, and a small
// decode helper used by the stage logic.
package mips_pkg;

    // Memory-access handshake states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mau_state_e;

    // Read data substituted when the bus never acknowledges (watchdog build).
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

    // Number of (flag, enable) branch-condition pairs resolved in MEM.
    localparam int NUM_BRANCH_CONDS = 6;

    // An instruction is a load only when it reads memory and does not write it;
    // MemWrite together with MemtoReg behaves as a store.
    function automatic logic is_load(input logic mem_write, input logic mem_to_reg);
        return mem_to_reg & ~mem_write;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Purely combinational branch decision: OR of every enabled condition flag.
module branch_resolve
    import mips_pkg::*;
(
    input  logic gtz,
    input  logic ne,
    input  logic eq,
    input  logic gez,
    input  logic lez,
    input  logic ltz,
    input  logic Branch_gtz,
    input  logic Branch_ne,
    input  logic Branch_eq,
    input  logic Branch_gez,
    input  logic Branch_lez,
    input  logic Branch_ltz,
    output logic branch_taken
);

    logic [NUM_BRANCH_CONDS-1:0] cond_flags;
    logic [NUM_BRANCH_CONDS-1:0] cond_en;
    logic [NUM_BRANCH_CONDS-1:0] cond_hit;

    assign cond_flags = {gtz, ne, eq, gez, lez, ltz};
    assign cond_en    = {Branch_gtz, Branch_ne, Branch_eq, Branch_gez, Branch_lez, Branch_ltz};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BRANCH_CONDS; gi++) begin : g_pair
            assign cond_hit[gi] = cond_flags[gi] & cond_en[gi];
        end
    endgenerate

    assign branch_taken = |cond_hit;

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: branch redirect, a three-state handshake with the
// data-memory bus that stalls the upstream pipeline while an access is
// outstanding, and the registered hand-off to MEM/WB.
// Optional feature: define MEM_TIMEOUT_EN to add a BUSY-state watchdog that
// abandons an unacknowledged access after TIMEOUT_CYCLES cycles, returns
// TIMEOUT_FILL as read data and raises the sticky mem_err flag.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] new_pc,
    input  logic [31:0] ALU_result,
    input  logic [31:0] rData_reg2,
    input  logic [4:0]  wAddr_reg,
    input  logic        RegWrite,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        gtz,
    input  logic        ne,
    input  logic        eq,
    input  logic        gez,
    input  logic        lez,
    input  logic        ltz,
    input  logic        Branch_gtz,
    input  logic        Branch_ne,
    input  logic        Branch_eq,
    input  logic        Branch_gez,
    input  logic        Branch_lez,
    input  logic        Branch_ltz,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_rdata,
    output logic [31:0] wb_alu,
    output logic [4:0]  wb_wAddr,
    output logic        wb_RegWrite,
    output logic        wb_MemtoReg,
    output logic        mem_err
);

    mau_state_e  state_q, state_d;
    logic        access;
    logic        load_instr;
    logic        retire;
    logic        timeout_hit;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;

    logic        wb_valid_q;
    logic [31:0] wb_rdata_q;
    logic [31:0] wb_alu_q;
    logic [4:0]  wb_wAddr_q;
    logic        wb_RegWrite_q;
    logic        wb_MemtoReg_q;

    assign access     = MemWrite | MemtoReg;
    assign load_instr = is_load(MemWrite, MemtoReg);

    // Branch resolution does not depend on the FSM; the PC only honours it when stall is low.
    branch_resolve u_branch_resolve (
        .gtz          (gtz),
        .ne           (ne),
        .eq           (eq),
        .gez          (gez),
        .lez          (lez),
        .ltz          (ltz),
        .Branch_gtz   (Branch_gtz),
        .Branch_ne    (Branch_ne),
        .Branch_eq    (Branch_eq),
        .Branch_gez   (Branch_gez),
        .Branch_lez   (Branch_lez),
        .Branch_ltz   (Branch_ltz),
        .branch_taken (branch_taken)
    );
    assign branch_target = new_pc;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q;

    // Watchdog: count unacknowledged BUSY cycles, fire on the last allowed one.
    always_comb begin
        wait_cnt_d  = '0;
        timeout_hit = 1'b0;
        if (state_q == BUSY && !mem_ack) begin
            timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
            wait_cnt_d  = timeout_hit ? '0 : wait_cnt_q + 1'b1;
        end
    end

    // Watchdog counter and sticky error flag; only reset clears the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (timeout_hit) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign mem_err = mem_err_q;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign mem_err            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, stall and retirement; acks outside BUSY are ignored.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = BUSY;
                    stall   = 1'b1;
                end else begin
                    retire  = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                retire  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered bus request; address and data latched as the access starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_req_q <= (state_d == BUSY);
            mem_we_q  <= (state_d == BUSY) && MemWrite;
            if (state_q == IDLE && state_d == BUSY) begin
                mem_addr_q  <= ALU_result;
                mem_wdata_q <= rData_reg2;
            end
        end
    end

    // Capture read data on the acknowledging BUSY cycle (or the fill value on timeout).
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state_q == BUSY) begin
            if (mem_ack) begin
                rdata_q <= mem_rdata;
            end else if (timeout_hit) begin
                rdata_q <= TIMEOUT_FILL;
            end
        end
    end

    // MEM/WB hand-off: one-cycle valid pulse after each retirement.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q    <= 1'b0;
            wb_rdata_q    <= '0;
            wb_alu_q      <= '0;
            wb_wAddr_q    <= '0;
            wb_RegWrite_q <= 1'b0;
            wb_MemtoReg_q <= 1'b0;
        end else begin
            wb_valid_q <= retire;
            if (retire) begin
                wb_rdata_q    <= load_instr ? rdata_q : 32'd0;
                wb_alu_q      <= ALU_result;
                wb_wAddr_q    <= wAddr_reg;
                wb_RegWrite_q <= RegWrite;
                wb_MemtoReg_q <= load_instr;
            end
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rdata    = wb_rdata_q;
    assign wb_alu      = wb_alu_q;
    assign wb_wAddr    = wb_wAddr_q;
    assign wb_RegWrite = wb_RegWrite_q;
    assign wb_MemtoReg = wb_MemtoReg_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: each issued instruction pushes its
// expected MEM/WB record; a negedge monitor pops and compares on wb_valid.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] new_pc, ALU_result, rData_reg2;
    logic [4:0]  wAddr_reg;
    logic        RegWrite, MemWrite, MemtoReg;
    logic        gtz, ne, eq, gez, lez, ltz;
    logic        Branch_gtz, Branch_ne, Branch_eq, Branch_gez, Branch_lez, Branch_ltz;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall, wb_valid;
    logic [31:0] wb_rdata, wb_alu;
    logic [4:0]  wb_wAddr;
    logic        wb_RegWrite, wb_MemtoReg, mem_err;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .new_pc(new_pc), .ALU_result(ALU_result), .rData_reg2(rData_reg2),
        .wAddr_reg(wAddr_reg), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .gtz(gtz), .ne(ne), .eq(eq), .gez(gez), .lez(lez), .ltz(ltz),
        .Branch_gtz(Branch_gtz), .Branch_ne(Branch_ne), .Branch_eq(Branch_eq),
        .Branch_gez(Branch_gez), .Branch_lez(Branch_lez), .Branch_ltz(Branch_ltz),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .wb_valid(wb_valid), .wb_rdata(wb_rdata), .wb_alu(wb_alu), .wb_wAddr(wb_wAddr),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .mem_err(mem_err)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [4:0]  waddr;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic [5:0]  ben;
        logic [5:0]  cond;
        logic        exp_bt;
        int          wait_n;
        logic        ack_all;
    } instr_t;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  waddr;
        logic        rw;
        logic        m2r;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] wdata,
                                  input logic [31:0] pc, input logic [31:0] rdata,
                                  input logic [4:0] waddr, input logic rw, input logic mw,
                                  input logic m2r, input logic [5:0] ben, input logic [5:0] cond,
                                  input logic exp_bt, input int wait_n, input logic ack_all);
        instr_t t;
        t.alu = alu; t.wdata = wdata; t.pc = pc; t.rdata = rdata; t.waddr = waddr;
        t.rw = rw; t.mw = mw; t.m2r = m2r; t.ben = ben; t.cond = cond;
        t.exp_bt = exp_bt; t.wait_n = wait_n; t.ack_all = ack_all;
        return t;
    endfunction

    task automatic drive(input instr_t in);
        new_pc     = in.pc;
        ALU_result = in.alu;
        rData_reg2 = in.wdata;
        wAddr_reg  = in.waddr;
        RegWrite   = in.rw;
        MemWrite   = in.mw;
        MemtoReg   = in.m2r;
        {gtz, ne, eq, gez, lez, ltz} = in.cond;
        {Branch_gtz, Branch_ne, Branch_eq, Branch_gez, Branch_lez, Branch_ltz} = in.ben;
    endtask

    // Drive one instruction, act as the memory, and hold it until it retires.
    task automatic issue(input string name, input instr_t in);
        int          stall_cnt, req_cnt, exp_st, exp_req;
        logic        access, load, to;
        logic [31:0] exp_rd;
        bit          done;
        wb_exp_t     e;
        access  = in.mw | in.m2r;
        load    = in.m2r & ~in.mw;
        to      = access && (in.wait_n < 0);
        exp_st  = !access ? 0 : (to ? TO + 1 : in.wait_n + 2);
        exp_req = !access ? 0 : (to ? TO : in.wait_n + 1);
        exp_rd  = !load ? 32'd0 : (to ? 32'hDEADBEEF : in.rdata);
        drive(in);
        mem_ack = in.ack_all;
        e.rdata = exp_rd; e.alu = in.alu; e.waddr = in.waddr; e.rw = in.rw; e.m2r = load;
        sb_q.push_back(e);
        stall_cnt = 0;
        req_cnt   = 0;
        done      = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check({name, "_br_taken"}, 32'(branch_taken), 32'(in.exp_bt));
                check({name, "_br_target"}, branch_target, in.pc);
            end
            if (mem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    check({name, "_addr"}, mem_addr, in.alu);
                    check({name, "_we"}, 32'(mem_we), 32'(in.mw));
                    if (in.mw) check({name, "_wdata"}, mem_wdata, in.wdata);
                end
            end
            mem_rdata = mem_req ? in.rdata : 32'hBAD0BAD0;
            mem_ack   = in.ack_all || (mem_req && in.wait_n >= 0 && req_cnt == in.wait_n + 1);
            if (stall) stall_cnt++;
            else       done = 1'b1;
        end
        check({name, "_retired"}, 32'(done), 32'd1);
        check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_st));
        check({name, "_req_cycles"}, 32'(req_cnt), 32'(exp_req));
        $display("[TB] txn %s: alu=%08h stall=%0d req=%0d", name, in.alu, stall_cnt, req_cnt);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        wb_exp_t e;
        if (!rst && wb_valid) begin
            check("wb_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("wb_rdata", wb_rdata, e.rdata);
                check("wb_alu", wb_alu, e.alu);
                check("wb_wAddr", 32'(wb_wAddr), 32'(e.waddr));
                check("wb_RegWrite", 32'(wb_RegWrite), 32'(e.rw));
                check("wb_MemtoReg", 32'(wb_MemtoReg), 32'(e.m2r));
                $display("[TB] wb alu=%08h rdata=%08h waddr=%0d", wb_alu, wb_rdata, wb_wAddr);
            end
        end
    end

    initial begin
        instr_t zero;
        zero = mk(0, 0, 0, 0, 5'd0, 0, 0, 0, 6'd0, 6'd0, 0, 0, 0);
        rst = 1'b1;
        drive(zero);
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_rdata", wb_rdata, 32'd0);
        check("rst_wb_alu", wb_alu, 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue("br_ne_taken", mk(32'h11, 0, 32'h40, 0, 5'd1, 1, 0, 0, 6'b010000, 6'b010000, 1, 0, 0));
        issue("br_ne_not", mk(32'h22, 0, 32'h80, 0, 5'd2, 1, 0, 0, 6'b010000, 6'b101111, 0, 0, 0));
        issue("br_ltz", mk(32'h33, 0, 32'hC0, 0, 5'd3, 0, 0, 0, 6'b000001, 6'b000001, 1, 0, 0));
        issue("load", mk(32'h100, 0, 32'h44, 32'h12345678, 5'd5, 1, 0, 1, 6'b001000, 6'b001000, 1, 2, 0));
        issue("store", mk(32'h200, 32'hCAFEF00D, 0, 32'h0, 5'd6, 0, 1, 0, 6'd0, 6'd0, 0, 0, 0));
        issue("both_store", mk(32'h204, 32'h0BADCAFE, 0, 32'h99999999, 5'd7, 1, 1, 1, 6'd0, 6'd0, 0, 1, 0));
        issue("load_ack_always", mk(32'h300, 0, 0, 32'h5A5AA5A5, 5'd8, 1, 0, 1, 6'd0, 6'd0, 0, 0, 1));
`ifdef MEM_TIMEOUT_EN
        check("err_before_timeout", 32'(mem_err), 32'd0);
        issue("load_timeout", mk(32'h400, 0, 0, 32'h1, 5'd9, 1, 0, 1, 6'd0, 6'd0, 0, -1, 0));
        check("err_after_timeout", 32'(mem_err), 32'd1);
        issue("alu_after_timeout", mk(32'h404, 0, 0, 0, 5'd10, 1, 0, 0, 6'd0, 6'd0, 0, 0, 0));
        check("err_sticky", 32'(mem_err), 32'd1);
`else
        issue("load_long_wait", mk(32'h400, 0, 0, 32'h600DF00D, 5'd9, 1, 0, 1, 6'd0, 6'd0, 0, 20, 0));
        check("err_tied_low", 32'(mem_err), 32'd0);
`endif

        // Reset while BUSY, then a late ack in the following cycle.
        drive(mk(32'h500, 0, 0, 0, 5'd11, 1, 0, 1, 6'd0, 6'd0, 0, 0, 0));
        @(negedge clk);
        check("midrst_idle_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_busy_req", 32'(mem_req), 32'd1);
        #1;
        rst = 1'b1;
        drive(zero);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        sb_q.push_back('{rdata: 32'd0, alu: 32'd0, waddr: 5'd0, rw: 1'b0, m2r: 1'b0});
        @(negedge clk);
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_wb_valid", 32'(wb_valid), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_mem_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;

        for (int i = 0; i < 6; i++) begin
            issue("alu_b2b", mk($urandom, 0, 0, 0, 5'(i + 16), 1, 0, 0, 6'd0, 6'd0, 0, 0, 0));
        end
        issue("bubble", zero);
        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
